// File: rtl/sam_pkg.sv
// Shared definitions for the sequencer row: opcodes, compare result type,
// controller states and the item-index width helper.
package sam_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_SCAN   = 3'd2;
    localparam logic [2:0] OP_INSERT = 3'd3;
    localparam logic [2:0] OP_CLEAR  = 3'd4;

    // eq: target == item; gt: target > item. Neither set means target < item.
    typedef struct packed {
        logic eq;
        logic gt;
    } cmp_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMP   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Index width able to hold 0..items, where items itself means "none".
    function automatic int clog2_items(input int items);
        return $clog2(items + 1);
    endfunction

endpackage

// File: rtl/seq_item_cmp.sv
// Lexicographic compare of one item against the target. Cell 0 is the most
// significant byte; the first unequal cell decides the result.
module seq_item_cmp
    import sam_pkg::*;
#(
    parameter int ITEM_CELLS = 4,
    parameter int CELL_SIZE  = 8
) (
    input  logic [ITEM_CELLS*CELL_SIZE-1:0] item,
    input  logic [ITEM_CELLS*CELL_SIZE-1:0] target,
    output cmp_t                            res
);

    always_comb begin
        logic                 eq_c;
        logic                 gt_c;
        logic [CELL_SIZE-1:0] t_cell;
        logic [CELL_SIZE-1:0] i_cell;
        eq_c   = 1'b1;
        gt_c   = 1'b0;
        t_cell = '0;
        i_cell = '0;
        for (int c = 0; c < ITEM_CELLS; c++) begin
            t_cell = target[(ITEM_CELLS-1-c)*CELL_SIZE +: CELL_SIZE];
            i_cell = item[(ITEM_CELLS-1-c)*CELL_SIZE +: CELL_SIZE];
            if (eq_c && (t_cell != i_cell)) begin
                gt_c = (t_cell > i_cell);
                eq_c = 1'b0;
            end
        end
        res.eq = eq_c;
        res.gt = gt_c;
    end

endmodule

// File: rtl/seq_item_row.sv
// One row of byte cells grouped into items: loads, clears, scans for a key and
// performs a sorted insert by shifting whole items up from the insertion point.
module seq_item_row
    import sam_pkg::*;
#(
    parameter int   CELL_SIZE  = 8,
    parameter int   ITEM_CELLS = 4,
    parameter int   CELLS      = 32,
    localparam int  ITEMS      = CELLS / ITEM_CELLS,
    localparam int  IW         = clog2_items(ITEMS),
    localparam int  ITEM_W     = ITEM_CELLS * CELL_SIZE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [2:0]                 op,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [ITEM_W-1:0]          target,
    input  logic [CELLS*CELL_SIZE-1:0] row_in,
    input  logic [ITEMS-1:0]           vmask_in,
    output logic [CELLS*CELL_SIZE-1:0] row_out,
    output logic [ITEMS-1:0]           vmask_out,
    output logic                       done,
    output logic                       err,
    output logic                       hit,
    output logic [IW-1:0]              hit_idx,
    output logic [IW-1:0]              ins_idx,
    output logic                       full
);

    if (CELLS % ITEM_CELLS != 0) begin : g_bad_geometry
        $error("seq_item_row: CELLS must be a multiple of ITEM_CELLS");
    end

    // Item i occupies row bits [i*ITEM_W +: ITEM_W].
    logic [ITEMS-1:0][ITEM_W-1:0] kreg_q, kreg_d;
    logic [ITEMS-1:0]             vmask_q, vmask_d;
    logic [ITEM_W-1:0]            tgt_q, tgt_d;
    state_e                       state_q, state_d;
    logic                         is_ins_q, is_ins_d;
    logic                         err_q, err_d;
    logic                         hit_q, hit_d;
    logic                         full_q, full_d;
    logic [IW-1:0]                hit_idx_q, hit_idx_d;
    logic [IW-1:0]                ins_idx_q, ins_idx_d;

    cmp_t [ITEMS-1:0]             item_res;
    logic [ITEMS-1:0]             item_eq;
    logic [ITEMS-1:0]             item_lt;
    logic [ITEMS-1:0]             vmask_norm;
    logic [ITEMS-1:0][ITEM_W-1:0] shift_kreg;
    logic [ITEMS-1:0]             shift_vmask;
    logic                         hit_c;
    logic                         full_c;
    logic [IW-1:0]                hit_idx_c;
    logic [IW-1:0]                ins_idx_c;

    for (genvar gi = 0; gi < ITEMS; gi++) begin : g_item
        seq_item_cmp #(
            .ITEM_CELLS (ITEM_CELLS),
            .CELL_SIZE  (CELL_SIZE)
        ) u_cmp (
            .item   (kreg_q[gi]),
            .target (tgt_q),
            .res    (item_res[gi])
        );
        // An invalid slot always reads as "target sorts before it".
        assign item_eq[gi] = vmask_q[gi] & item_res[gi].eq;
        assign item_lt[gi] = ~vmask_q[gi] | (~item_res[gi].eq & ~item_res[gi].gt);
    end

    assign hit_c  = |item_eq;
    assign full_c = &vmask_q;

    always_comb begin
        hit_idx_c = IW'(ITEMS);
        ins_idx_c = IW'(ITEMS);
        for (int i = ITEMS - 1; i >= 0; i--) begin
            if (item_eq[i]) hit_idx_c = IW'(i);
            if (item_lt[i]) ins_idx_c = IW'(i);
        end
        if (full_c) ins_idx_c = IW'(ITEMS);
    end

    // Valid mask is kept as a prefix: nothing survives past the first hole.
    always_comb begin
        vmask_norm = vmask_in;
        for (int i = 1; i < ITEMS; i++) begin
            vmask_norm[i] = vmask_in[i] & vmask_norm[i-1];
        end
    end

    for (genvar gi = 0; gi < ITEMS; gi++) begin : g_shift
        localparam logic [IW-1:0] POS = IW'(gi);
        if (gi == 0) begin : g_head
            assign shift_kreg[gi]  = (ins_idx_q == POS) ? tgt_q : kreg_q[gi];
            assign shift_vmask[gi] = (ins_idx_q == POS) ? 1'b1  : vmask_q[gi];
        end else begin : g_body
            assign shift_kreg[gi]  = (POS > ins_idx_q)  ? kreg_q[gi-1] :
                                     (POS == ins_idx_q) ? tgt_q        : kreg_q[gi];
            assign shift_vmask[gi] = (POS > ins_idx_q)  ? vmask_q[gi-1] :
                                     (POS == ins_idx_q) ? 1'b1          : vmask_q[gi];
        end
    end

    always_comb begin
        state_d   = state_q;
        kreg_d    = kreg_q;
        vmask_d   = vmask_q;
        tgt_d     = tgt_q;
        is_ins_d  = is_ins_q;
        err_d     = err_q;
        hit_d     = hit_q;
        full_d    = full_q;
        hit_idx_d = hit_idx_q;
        ins_idx_d = ins_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_LOAD: begin
                            kreg_d  = row_in;
                            vmask_d = vmask_norm;
                            err_d   = 1'b0;
                            state_d = ST_DONE;
                        end
                        OP_CLEAR: begin
                            vmask_d = '0;
                            err_d   = 1'b0;
                            state_d = ST_DONE;
                        end
                        OP_SCAN, OP_INSERT: begin
                            tgt_d    = target;
                            is_ins_d = (op == OP_INSERT);
                            err_d    = 1'b0;
                            state_d  = ST_CMP;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CMP: begin
                hit_d     = hit_c;
                full_d    = full_c;
                hit_idx_d = hit_idx_c;
                ins_idx_d = ins_idx_c;
                if (is_ins_q && !full_c) begin
                    state_d = ST_SHIFT;
                end else begin
                    err_d   = is_ins_q;
                    state_d = ST_DONE;
                end
            end
            ST_SHIFT: begin
                kreg_d  = shift_kreg;
                vmask_d = shift_vmask;
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            kreg_q    <= '0;
            vmask_q   <= '0;
            tgt_q     <= '0;
            is_ins_q  <= 1'b0;
            err_q     <= 1'b0;
            hit_q     <= 1'b0;
            full_q    <= 1'b0;
            hit_idx_q <= IW'(ITEMS);
            ins_idx_q <= IW'(ITEMS);
        end else begin
            state_q   <= state_d;
            kreg_q    <= kreg_d;
            vmask_q   <= vmask_d;
            tgt_q     <= tgt_d;
            is_ins_q  <= is_ins_d;
            err_q     <= err_d;
            hit_q     <= hit_d;
            full_q    <= full_d;
            hit_idx_q <= hit_idx_d;
            ins_idx_q <= ins_idx_d;
        end
    end

    assign op_ready  = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign hit       = hit_q;
    assign full      = full_q;
    assign hit_idx   = hit_idx_q;
    assign ins_idx   = ins_idx_q;
    assign row_out   = kreg_q;
    assign vmask_out = vmask_q;

endmodule
